// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier with start/busy/done handshake.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high reset
//   start        - request a multiply; accepted only in IDLE or DONE
//   signed_mode  - 1 = two's-complement operands, 0 = unsigned; captured with start
//   multiplicand - M operand, captured with start
//   multiplier   - Q operand, captured with start
//   busy         - high while iterating
//   done         - one-cycle pulse when product is valid
//   product      - 2*WIDTH-bit result; holds until the next completion or reset
//
// A, M and Q carry one extra bit so that the most-negative signed operand and
// the full unsigned range both fit as WIDTH+1-bit two's-complement values.
// Unsigned operands are zero-extended into that bit, which makes the extension
// bit a real multiplier bit, hence one extra iteration in unsigned mode.
module booth_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_SIGNED   = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_UNSIGNED = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 mode_q, mode_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       a_sum;
  logic [WIDTH:0]       a_sh;
  logic [WIDTH:0]       q_sh;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      product_q <= product_d;
    end
  end

  // Booth add/subtract followed by the arithmetic right shift of {A,Q,Q-1}.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_q;
      2'b01:   a_sum = a_q + m_q;
      default: a_sum = a_q;
    endcase
    a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_sh = {a_sum[0], q_q[WIDTH:1]};
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    mode_d    = mode_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          q_d     = {signed_mode & multiplier[WIDTH-1], multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          mode_d  = signed_mode;
          count_d = signed_mode ? CNT_SIGNED : CNT_UNSIGNED;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_sh;
        q_d     = q_sh;
        qm1_d   = q_q[0];
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = S_DONE;
          // Signed runs stop one shift short, leaving the unconsumed
          // extension bit in Q[0]; unsigned runs shift it out entirely.
          if (mode_q) begin
            product_d = {a_sh[WIDTH-1:0], q_sh[WIDTH:1]};
          end else begin
            product_d = {a_sh[WIDTH-2:0], q_sh[WIDTH:0]};
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: a WIDTH=4 instance for directed cases and a
// WIDTH=8 instance for randomised pairs, both checked every cycle against a
// latency/arithmetic model of the multiply unit.
module tb_booth_seq_mult;

  logic       clk;
  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [1:0] sm_v;
  logic [7:0] mc_v [2];
  logic [7:0] mp_v [2];

  logic       busy4, done4, busy8, done8;
  logic [7:0] prod4;
  logic [15:0] prod8;

  logic        dut_busy [2];
  logic        dut_done [2];
  logic [15:0] dut_prod [2];

  int checks;
  int failures;
  bit chk_en;

  // Model state: per instance
  bit          m_busy [2];
  int          m_left [2];
  bit          m_done [2];
  logic [15:0] m_prod [2];
  logic [15:0] m_pend [2];
  int          accepted [2];
  int          done_seen [2];
  longint      ma, mb, mpv;
  int          mw;

  booth_seq_mult #(.WIDTH(4)) u4 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .signed_mode(sm_v[0]),
    .multiplicand(mc_v[0][3:0]), .multiplier(mp_v[0][3:0]),
    .busy(busy4), .done(done4), .product(prod4)
  );

  booth_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .signed_mode(sm_v[1]),
    .multiplicand(mc_v[1]), .multiplier(mp_v[1]),
    .busy(busy8), .done(done8), .product(prod8)
  );

  assign dut_busy[0] = busy4;
  assign dut_busy[1] = busy8;
  assign dut_done[0] = done4;
  assign dut_done[1] = done8;
  assign dut_prod[0] = {8'd0, prod4};
  assign dut_prod[1] = prod8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start yields the exact product after
  // WIDTH (signed) or WIDTH+1 (unsigned) busy cycles, then a one-cycle done.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mw = (d == 0) ? 4 : 8;
      if (rst_v[d]) begin
        m_busy[d] = 1'b0;
        m_left[d] = 0;
        m_done[d] = 1'b0;
        m_prod[d] = 16'd0;
      end else if (m_busy[d]) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
          m_prod[d] = m_pend[d];
        end
      end else begin
        m_done[d] = 1'b0;
        if (start_v[d]) begin
          ma = longint'(mc_v[d]) & ((longint'(1) << mw) - 1);
          mb = longint'(mp_v[d]) & ((longint'(1) << mw) - 1);
          if (sm_v[d] && ma[mw-1]) ma = ma - (longint'(1) << mw);
          if (sm_v[d] && mb[mw-1]) mb = mb - (longint'(1) << mw);
          mpv = ma * mb;
          m_pend[d] = 16'(mpv & ((longint'(1) << (2 * mw)) - 1));
          m_busy[d] = 1'b1;
          m_left[d] = sm_v[d] ? mw : mw + 1;
          accepted[d]++;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy%0d", d), 64'(dut_busy[d]), 64'(m_busy[d]));
        check($sformatf("done%0d", d), 64'(dut_done[d]), 64'(m_done[d]));
        check($sformatf("product%0d", d), 64'(dut_prod[d]), 64'(m_prod[d]));
        if (dut_done[d] === 1'b1) done_seen[d]++;
      end
    end
  end

  task automatic launch(input int d, input bit sm, input logic [7:0] a, input logic [7:0] b);
    start_v[d] = 1'b1;
    sm_v[d]    = sm;
    mc_v[d]    = a;
    mp_v[d]    = b;
  endtask

  // Waits (bounded) for done, starting at a negedge; optionally keeps start
  // high with fresh operands while the unit is running.
  task automatic wait_done(input int d, input bit hold, output logic [15:0] prod,
                           output int busy_cycles, output int cycles);
    bit ok;
    ok = 1'b0;
    busy_cycles = 0;
    cycles = 0;
    prod = 16'hxxxx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (dut_busy[d] === 1'b1) busy_cycles++;
      if (dut_done[d] === 1'b1) begin
        prod = dut_prod[d];
        ok = 1'b1;
        break;
      end
      if (hold) begin
        mc_v[d] = 8'($urandom);
        mp_v[d] = 8'($urandom);
        sm_v[d] = 1'($urandom);
      end else begin
        start_v[d] = 1'b0;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout%0d: no done within 40 cycles", d);
    end
    start_v[d] = hold ? 1'b1 : 1'b0;
  endtask

  task automatic directed(input string name, input bit sm, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_p, input int exp_busy);
    logic [15:0] p;
    int bc, cc;
    launch(0, sm, a, b);
    wait_done(0, 1'b0, p, bc, cc);
    check({name, "_prod"}, 64'(p), 64'(exp_p));
    check({name, "_busy"}, 64'(bc), 64'(exp_busy));
    @(negedge clk);
    check({name, "_done_width"}, 64'(dut_done[0]), 64'd0);
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] ref_p;
    longint ra, rb;
    int bc, cc;
    int acc_base, done_base;

    checks = 0;
    failures = 0;
    chk_en = 1'b0;
    rst_v = 2'b11;
    start_v = 2'b00;
    sm_v = 2'b00;
    mc_v[0] = 8'd0; mc_v[1] = 8'd0;
    mp_v[0] = 8'd0; mp_v[1] = 8'd0;
    repeat (2) @(negedge clk);
    rst_v = 2'b00;
    chk_en = 1'b1;

    // Reset state
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_done", 64'(done4), 64'd0);
    check("rst_prod", 64'(prod4), 64'd0);

    directed("s_3xm2",   1'b1, 8'h3, 8'hE, 8'hFA, 4);
    directed("s_m8xm8",  1'b1, 8'h8, 8'h8, 8'h40, 4);
    directed("u_15x15",  1'b0, 8'hF, 8'hF, 8'hE1, 5);
    directed("s_m1xm1",  1'b1, 8'hF, 8'hF, 8'h01, 4);
    directed("u_8x8",    1'b0, 8'h8, 8'h8, 8'h40, 5);
    directed("s_7xm8",   1'b1, 8'h7, 8'h8, 8'hC8, 4);

    // Start held through RUN, then back-to-back 7 x 7 in the DONE cycle
    launch(0, 1'b1, 8'h3, 8'h5);
    wait_done(0, 1'b1, p, bc, cc);
    check("hold_prod", 64'(p), 64'h0F);
    launch(0, 1'b1, 8'h7, 8'h7);
    wait_done(0, 1'b0, p, bc, cc);
    check("b2b_prod", 64'(p), 64'h31);
    check("b2b_spacing", 64'(cc), 64'd5);
    @(negedge clk);

    // Reset during iteration 2 of 5 x 5
    launch(0, 1'b1, 8'h5, 8'h5);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("abort_busy", 64'(busy4), 64'd0);
    check("abort_done", 64'(done4), 64'd0);
    check("abort_prod", 64'(prod4), 64'd0);
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(done4), 64'd0);
    directed("s_2x3", 1'b1, 8'h2, 8'h3, 8'h06, 4);

    // Randomised WIDTH=8, 1000 pairs per mode
    acc_base = accepted[1];
    done_base = done_seen[1];
    for (int mode = 0; mode < 2; mode++) begin
      for (int n = 0; n < 1000; n++) begin
        launch(1, mode[0], 8'($urandom), 8'($urandom));
        ra = mode ? longint'($signed(mc_v[1])) : longint'(mc_v[1]);
        rb = mode ? longint'($signed(mp_v[1])) : longint'(mp_v[1]);
        ref_p = 16'(ra * rb);
        wait_done(1, 1'b0, p, bc, cc);
        check("rand_prod", 64'(p), 64'(ref_p));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    check("rand_done_count", 64'(done_seen[1] - done_base), 64'(accepted[1] - acc_base));
    check("rand_accept_count", 64'(accepted[1] - acc_base), 64'd2000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
